job_launcher: RTL and testbench

JOB_LAUNCHER -- requirements
Module: job_launcher

---
 rtl/job_launcher.sv | 266 ++++++++++++++++++++++++++
 tb/tb_job_launcher.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/job_launcher.sv
// job_launcher: accepts a ten-word CSR descriptor and programs an accelerator
// over an AXI4-Lite master. It writes words 1..9 and then word 0, which holds
// the start bit. It then waits for a rising edge of compute_done, bounded by
// TIMEOUT_CYCLES, reads the status register and reports a 2-bit result code.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   job_valid/job_ready/job_desc descriptor handshake; word i at [32i+31:32i]
//   m_axi_aw*, m_axi_w*, m_axi_b* AXI4-Lite write channels (awprot=0, wstrb=F)
//   m_axi_ar*, m_axi_r*          AXI4-Lite read channels (arprot=0)
//   compute_done                 accelerator completion level
//   done_valid/done_ready/done_status result handshake
//                                (00 ok, 01 AXI error, 10 exception, 11 timeout)
//   busy                         high whenever not idle
module job_launcher #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned STATUS_OFFSET  = 32'h28,
  parameter int unsigned EXC_BIT        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [10*DATA_WIDTH-1:0] job_desc,
  output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [DATA_WIDTH-1:0]    m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]  m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [2:0]               m_axi_arprot,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  input  logic                     compute_done,
  output logic                     done_valid,
  output logic [1:0]               done_status,
  input  logic                     done_ready,
  output logic                     busy
);

  localparam int unsigned NUM_WORDS = 10;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned DESC_W    = NUM_WORDS * DATA_WIDTH;
  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_WORDS - 1);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_AXI = 2'b01;
  localparam logic [1:0] ST_EXC = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    WAITDONE,
    RADDR,
    RDATA,
    REPORT
  } state_t;

  state_t                 state_q, state_d;
  logic [DESC_W-1:0]      desc_q, desc_d;
  logic [IDX_W-1:0]       idx_q, idx_d, idx_nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cd_prev_q;
  logic                   cd_edge;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   bready_q, bready_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic                   done_valid_q, done_valid_d;
  logic [1:0]             done_status_q, done_status_d;
  logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

  // Only the exception bit of the status word is meaningful here.
  logic unused_rdata;
  assign unused_rdata = ^m_axi_rdata;

  // Byte address of CSR word i.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] i);
    return ADDR_WIDTH'({i, 2'b00});
  endfunction

  // CSR word i of a descriptor.
  function automatic logic [DATA_WIDTH-1:0] word_of(input logic [DESC_W-1:0] d,
                                                    input logic [IDX_W-1:0]  i);
    return d[32'(i) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      desc_q        <= '0;
      idx_q         <= IDX_W'(1);
      cnt_q         <= '0;
      cd_prev_q     <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      done_valid_q  <= 1'b0;
      done_status_q <= ST_OK;
      awaddr_q      <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      desc_q        <= desc_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      cd_prev_q     <= compute_done;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      done_valid_q  <= done_valid_d;
      done_status_q <= done_status_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
    end
  end

  // Sampled continuously so a level already high on entering WAITDONE never counts.
  assign cd_edge = compute_done && !cd_prev_q;

  // Word order 1..9 then 0: the start bit lives in word 0.
  assign idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    desc_d        = desc_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    done_valid_d  = done_valid_q;
    done_status_d = done_status_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;

    case (state_q)
      IDLE: begin
        if (job_valid) begin
          desc_d    = job_desc;
          idx_d     = IDX_W'(1);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = addr_of(IDX_W'(1));
          wdata_d   = word_of(job_desc, IDX_W'(1));
          state_d   = WADDR;
        end
      end

      WADDR: begin
        // AW and W complete independently; move on once both are done.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end

      WRESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp != 2'b00) begin
            done_status_d = ST_AXI;
            done_valid_d  = 1'b1;
            state_d       = REPORT;
          end else if (idx_q != '0) begin
            idx_d     = idx_nxt;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = addr_of(idx_nxt);
            wdata_d   = word_of(desc_q, idx_nxt);
            state_d   = WADDR;
          end else begin
            cnt_d   = '0;
            state_d = WAITDONE;
          end
        end
      end

      WAITDONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An edge on the final counted cycle still wins over the timeout.
        if (cd_edge) begin
          arvalid_d = 1'b1;
          state_d   = RADDR;
        end else if (cnt_q == CNT_LIMIT) begin
          done_status_d = ST_TMO;
          done_valid_d  = 1'b1;
          state_d       = REPORT;
        end
      end

      RADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end

      RDATA: begin
        if (m_axi_rvalid) begin
          rready_d     = 1'b0;
          done_valid_d = 1'b1;
          state_d      = REPORT;
          if (m_axi_rresp != 2'b00)      done_status_d = ST_AXI;
          else if (m_axi_rdata[EXC_BIT]) done_status_d = ST_EXC;
          else                           done_status_d = ST_OK;
        end
      end

      REPORT: begin
        if (done_ready) begin
          done_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign job_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = ADDR_WIDTH'(STATUS_OFFSET);
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign done_valid    = done_valid_q;
  assign done_status   = done_status_q;

endmodule

// File: tb/tb_job_launcher.sv
// Bench for job_launcher: an AXI4-Lite slave, accelerator and result consumer
// acting on the falling edge, checked against a descriptor-level model.
`timescale 1ns/1ps
module tb_job_launcher;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk;
  logic            rst;
  logic            job_valid;
  logic            job_ready;
  logic [10*DW-1:0] job_desc;
  logic [AW-1:0]   m_axi_awaddr;
  logic [2:0]      m_axi_awprot;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [3:0]      m_axi_wstrb;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid;
  logic            m_axi_bready;
  logic [AW-1:0]   m_axi_araddr;
  logic [2:0]      m_axi_arprot;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rvalid;
  logic            m_axi_rready;
  logic            compute_done;
  logic            done_valid;
  logic [1:0]      done_status;
  logic            done_ready;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  job_launcher #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO),
    .STATUS_OFFSET(32'h28), .EXC_BIT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_desc(job_desc),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .compute_done(compute_done),
    .done_valid(done_valid), .done_status(done_status), .done_ready(done_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    job_valid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
    compute_done = 1'b0; done_ready = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_awvalid"},    64'(m_axi_awvalid), 64'(0));
    check({tag, "_wvalid"},     64'(m_axi_wvalid),  64'(0));
    check({tag, "_bready"},     64'(m_axi_bready),  64'(0));
    check({tag, "_arvalid"},    64'(m_axi_arvalid), 64'(0));
    check({tag, "_rready"},     64'(m_axi_rready),  64'(0));
    check({tag, "_done_valid"}, 64'(done_valid),    64'(0));
    check({tag, "_job_ready"},  64'(job_ready),     64'(1));
    check({tag, "_busy"},       64'(busy),          64'(0));
  endtask

  // One job. err_addr: byte address answered with SLVERR (-1 none).
  // cd_mode: 0 pulse cd_delay cycles after the start write, 1 held low, 2 held high.
  // *_d: cycles each valid waits for its ready (1 = immediate); dr_d: cycles done_ready stays low.
  // rst_at: pulse rst on the first AW cycle after that many writes (-1 never).
  task automatic run_job(input int err_addr, input int cd_mode, input int cd_delay,
                         input logic [31:0] st_val, input bit rresp_err,
                         input int aw_d, input int w_d, input int ar_d, input int dr_d,
                         input int rst_at);
    logic [10*DW-1:0] desc;
    int exp_addr[$];
    int got_addr[$];
    logic [31:0] got_data[$];
    bit wr_err, edge_ok, exp_ar, accepted, acc_pend, fin_seen, r_pend, dv_seen, fired;
    bit aw_fired, w_fired, ar_fired;
    logic [1:0] exp_status, first_status;
    logic [AW-1:0] aw_prev;
    logic [31:0] w_prev;
    int cyc, acc_cyc, fin_cyc, aw_hi, w_hi, ar_hi, dr_hi, ar_n, b_n, wait_n, pend, nlog;

    for (int i = 0; i < 10; i++) desc[i*32 +: 32] = $urandom();

    // Reference model: write list, whether the status read happens, result code.
    wr_err = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      exp_addr.push_back((k % 10) * 4);
      if ((k % 10) * 4 == err_addr) begin
        wr_err = 1'b1;
        break;
      end
    end
    edge_ok    = (cd_mode == 0) && (cd_delay >= 1) && (cd_delay <= TO);
    exp_ar     = !wr_err && edge_ok;
    exp_status = wr_err ? 2'b01 : !edge_ok ? 2'b11 : rresp_err ? 2'b01 :
                 st_val[2] ? 2'b10 : 2'b00;

    accepted = 0; acc_pend = 0; fin_seen = 0; r_pend = 0; dv_seen = 0; fired = 0;
    aw_fired = 0; w_fired = 0; ar_fired = 0; first_status = 2'b00;
    aw_prev = '0; w_prev = '0;
    cyc = 0; acc_cyc = 0; fin_cyc = 0; aw_hi = 0; w_hi = 0; ar_hi = 0; dr_hi = 0;
    ar_n = 0; b_n = 0; wait_n = 0;

    @(negedge clk);
    compute_done = (cd_mode == 2);
    while (!fired && cyc < 400) begin
      // Job channel; the descriptor is scrambled after acceptance.
      if (acc_pend) begin
        job_valid = 1'b0; job_desc = ~desc; acc_pend = 0;
      end else if (!accepted) begin
        job_valid = 1'b1; job_desc = desc;
        if (job_ready) begin accepted = 1; acc_pend = 1; acc_cyc = cyc; end
      end

      if (rst_at >= 0 && m_axi_awvalid && aw_hi == 0 && got_addr.size() == rst_at) begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_quiet("mid_reset");
        return;
      end

      // Write response, answered as soon as both halves of a write have gone.
      nlog = (got_addr.size() < got_data.size()) ? got_addr.size() : got_data.size();
      pend = nlog - b_n;
      if (m_axi_bready) check("bready_only_when_owed", 64'(pend > 0), 64'(1));
      m_axi_bvalid = (pend > 0);
      m_axi_bresp  = 2'b00;
      if (m_axi_bvalid && got_addr[b_n] == err_addr) m_axi_bresp = 2'b10;
      if (m_axi_bvalid && m_axi_bready) begin
        b_n++;
        if (m_axi_bresp != 2'b00 || got_addr[b_n-1] == 0) begin
          fin_seen = 1; fin_cyc = cyc;
        end
      end

      // Write address.
      if (aw_fired) check("awvalid_drop", 64'(m_axi_awvalid), 64'(0));
      else if (aw_hi > 0) begin
        check("awvalid_hold", 64'(m_axi_awvalid), 64'(1));
        check("awaddr_stable", 64'(m_axi_awaddr), 64'(aw_prev));
      end
      aw_fired = 0; m_axi_awready = 1'b0;
      if (m_axi_awvalid) begin
        aw_hi++;
        m_axi_awready = (aw_hi >= aw_d);
        if (m_axi_awready) begin
          got_addr.push_back(int'(m_axi_awaddr)); aw_hi = 0; aw_fired = 1;
        end
      end else aw_hi = 0;
      aw_prev = m_axi_awaddr;

      // Write data.
      if (w_fired) check("wvalid_drop", 64'(m_axi_wvalid), 64'(0));
      else if (w_hi > 0) begin
        check("wvalid_hold", 64'(m_axi_wvalid), 64'(1));
        check("wdata_stable", 64'(m_axi_wdata), 64'(w_prev));
      end
      w_fired = 0; m_axi_wready = 1'b0;
      if (m_axi_wvalid) begin
        w_hi++;
        m_axi_wready = (w_hi >= w_d);
        if (m_axi_wready) begin
          got_data.push_back(m_axi_wdata); w_hi = 0; w_fired = 1;
        end
      end else w_hi = 0;
      w_prev = m_axi_wdata;

      // Read data, then read address.
      if (m_axi_rready) check("rready_only_after_ar", 64'(ar_n), 64'(1));
      m_axi_rvalid = r_pend;
      m_axi_rdata  = st_val;
      m_axi_rresp  = rresp_err ? 2'b10 : 2'b00;
      if (m_axi_rvalid && m_axi_rready) r_pend = 0;
      if (ar_fired) check("arvalid_drop", 64'(m_axi_arvalid), 64'(0));
      else if (ar_hi > 0) check("arvalid_hold", 64'(m_axi_arvalid), 64'(1));
      ar_fired = 0; m_axi_arready = 1'b0;
      if (m_axi_arvalid) begin
        ar_hi++;
        m_axi_arready = (ar_hi >= ar_d);
        if (m_axi_arready) begin
          check("araddr", 64'(m_axi_araddr), 64'(6'h28));
          ar_n++; ar_hi = 0; ar_fired = 1; r_pend = 1;
        end
      end else ar_hi = 0;

      // Accelerator.
      if (cd_mode == 0)
        compute_done = fin_seen && !wr_err && (cyc - fin_cyc >= cd_delay) &&
                       (cyc - fin_cyc < cd_delay + 2);
      if (fin_seen && cyc > fin_cyc && !dv_seen && !done_valid && !m_axi_arvalid && ar_n == 0)
        wait_n++;

      // Result consumer.
      done_ready = 1'b0;
      if (dv_seen) begin
        check("done_valid_held", 64'(done_valid), 64'(1));
        check("done_status_stable", 64'(done_status), 64'(first_status));
      end else if (done_valid) begin
        dv_seen = 1; first_status = done_status;
        check("done_status", 64'(done_status), 64'(exp_status));
      end
      if (dv_seen) begin
        dr_hi++;
        if (dr_hi > dr_d) begin done_ready = 1'b1; fired = 1; end
      end

      cyc++;
      @(negedge clk);
    end

    idle_inputs();
    check("job_completed", 64'(fired), 64'(1));
    check("after_done_valid", 64'(done_valid), 64'(0));
    check("after_job_ready", 64'(job_ready), 64'(1));
    check("write_count", 64'(got_addr.size()), 64'(exp_addr.size()));
    foreach (exp_addr[i]) begin
      if (i < got_addr.size()) check("awaddr_seq", 64'(got_addr[i]), 64'(exp_addr[i]));
      if (i < got_data.size())
        check("wdata_seq", 64'(got_data[i]), 64'(desc[(exp_addr[i] / 4) * 32 +: 32]));
    end
    check("ar_count", 64'(ar_n), 64'(exp_ar));
    if (aw_d == 1 && w_d == 1 && !wr_err && fin_seen)
      check("start_write_latency", 64'(fin_cyc - acc_cyc), 64'(20));
    if (!wr_err && !edge_ok) check("waitdone_cycles", 64'(wait_n), 64'(TO));
  endtask

  initial begin
    rst = 1'b1;
    job_desc = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_done_status", 64'(done_status), 64'(0));
    check("awprot", 64'(m_axi_awprot), 64'(0));
    check("arprot", 64'(m_axi_arprot), 64'(0));
    check("wstrb", 64'(m_axi_wstrb), 64'(4'hF));
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait slave, clean status.
    run_job(-1, 0, 5, 32'h0, 1'b0, 1, 1, 1, 0, -1);
    // Slow AW, immediate W; then slow W, immediate AW.
    run_job(-1, 0, 5, 32'h0, 1'b0, 3, 1, 1, 0, -1);
    run_job(-1, 0, 3, 32'h0, 1'b0, 1, 4, 2, 0, -1);
    // SLVERR on 0x0C, and on the start write itself.
    run_job(12, 0, 5, 32'h0, 1'b0, 1, 1, 1, 0, -1);
    run_job(0, 0, 5, 32'h0, 1'b0, 2, 1, 1, 0, -1);
    // Timeouts: done held low, done already high on entry, edge one cycle too late.
    run_job(-1, 1, 0, 32'h0, 1'b0, 1, 1, 1, 0, -1);
    run_job(-1, 2, 0, 32'h0, 1'b0, 1, 1, 1, 0, -1);
    run_job(-1, 0, TO + 1, 32'h0, 1'b0, 1, 1, 1, 0, -1);
    // Edge on the last counted cycle beats the timeout; earliest edge.
    run_job(-1, 0, TO, 32'h0, 1'b0, 1, 1, 1, 0, -1);
    run_job(-1, 0, 1, 32'h0, 1'b0, 1, 1, 1, 0, -1);
    // Exception status with a slow consumer; read error beats the exception bit.
    run_job(-1, 0, 5, 32'h4, 1'b0, 1, 1, 3, 4, -1);
    run_job(-1, 0, 5, 32'h4, 1'b1, 1, 1, 1, 1, -1);
    // Reset while awvalid is high, then a normal job.
    run_job(-1, 0, 5, 32'h0, 1'b0, 3, 1, 1, 0, 3);
    run_job(-1, 0, 5, 32'h0, 1'b0, 1, 1, 1, 0, -1);

    for (int j = 0; j < 24; j++) begin
      int e, m;
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) * 4 : -1;
      m = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_job(e, m, int'($urandom_range(1, TO + 2)), $urandom(), ($urandom_range(0, 5) == 0),
              int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
